// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer.
//   WORD_W     : data/address width
//   mem_mode_e : memory access size encoding (BYTE/HALF/WORD; 2'd3 is unused)
//   mem_size() : byte count of an access; unknown encodings count as WORD
package store_buffer_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_mode_e;

  function automatic logic [2:0] mem_size(mem_mode_e mode);
    case (mode)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline/memory-side bundle of the store buffer.
//   store side : storeValid, storeAddress, storeData, storeMode -> storeReady
//   load check : loadValid, loadAddress, loadMode -> loadStall
//   drain side : drainEn -> memWrite, memAddress, memWriteData, memMode
//   status     : empty
// master = pipeline/memory environment, slave = store buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic                storeValid;
  logic [WORD_W-1:0]   storeAddress;
  logic [WORD_W-1:0]   storeData;
  mem_mode_e           storeMode;
  logic                storeReady;

  logic                loadValid;
  logic [WORD_W-1:0]   loadAddress;
  mem_mode_e           loadMode;
  logic                loadStall;

  logic                drainEn;
  logic                memWrite;
  logic [WORD_W-1:0]   memAddress;
  logic [WORD_W-1:0]   memWriteData;
  mem_mode_e           memMode;

  logic                empty;

  modport master (
    output storeValid, storeAddress, storeData, storeMode,
    output loadValid, loadAddress, loadMode, drainEn,
    input  storeReady, loadStall, memWrite, memAddress, memWriteData, memMode, empty
  );

  modport slave (
    input  storeValid, storeAddress, storeData, storeMode,
    input  loadValid, loadAddress, loadMode, drainEn,
    output storeReady, loadStall, memWrite, memAddress, memWriteData, memMode, empty
  );

endinterface

// File: rtl/store_buffer_overlap.sv
// byte_range_overlap: flags whether two accesses touch a common byte.
//   i_a_addr/i_a_mode : first access (byte address, size)
//   i_b_addr/i_b_mode : second access
//   o_overlap         : 1 when the byte ranges intersect
// Ranges are [addr, addr+size-1] in WORD_W+1 bits so nothing wraps past the top.
module byte_range_overlap
  import store_buffer_pkg::*;
(
  input  logic [WORD_W-1:0] i_a_addr,
  input  mem_mode_e         i_a_mode,
  input  logic [WORD_W-1:0] i_b_addr,
  input  mem_mode_e         i_b_mode,
  output logic              o_overlap
);

  logic [WORD_W:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;

  assign w_a_lo = {1'b0, i_a_addr};
  assign w_b_lo = {1'b0, i_b_addr};
  assign w_a_hi = w_a_lo + (WORD_W+1)'(mem_size(i_a_mode)) - (WORD_W+1)'(1);
  assign w_b_hi = w_b_lo + (WORD_W+1)'(mem_size(i_b_mode)) - (WORD_W+1)'(1);

  assign o_overlap = (w_a_lo <= w_b_hi) && (w_b_lo <= w_a_hi);

endmodule

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry FIFO of pending stores between MEM and data memory.
//   clk, reset : clock, synchronous active-high reset
//   sb (slave) : store enqueue, load-overlap stall, memory drain port, empty
// Drains one store per cycle when drainEn is high; a full buffer still accepts
// a store in a cycle it drains. Loads overlapping any pending or incoming store
// stall (no forwarding).
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  store_buffer_if.slave sb
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [WORD_W-1:0] r_addr [DEPTH];
  logic [WORD_W-1:0] r_data [DEPTH];
  mem_mode_e         r_mode [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [PTR_W:0]    r_count;

  logic              w_cnt_zero, w_deq, w_enq, w_empty;
  logic [DEPTH-1:0]  w_entry_ovl;
  logic              w_in_ovl;

  assign w_cnt_zero = (r_count == '0);
  assign w_deq      = sb.drainEn && !w_cnt_zero;
  assign w_enq      = sb.storeValid && sb.storeReady;
  // Reset forces the idle view of every output in the reset cycle itself.
  assign w_empty    = reset || w_cnt_zero;

  assign sb.storeReady   = reset || (r_count < DEPTH_C) || w_deq;
  assign sb.memWrite     = w_deq && !reset;
  assign sb.empty        = w_empty;
  assign sb.memAddress   = w_empty ? '0 : r_addr[r_head];
  assign sb.memWriteData = w_empty ? '0 : r_data[r_head];
  assign sb.memMode      = w_empty ? MEM_BYTE : r_mode[r_head];

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry_ovl
    byte_range_overlap u_ovl (
      .i_a_addr  (r_addr[g]),
      .i_a_mode  (r_mode[g]),
      .i_b_addr  (sb.loadAddress),
      .i_b_mode  (sb.loadMode),
      .o_overlap (w_entry_ovl[g])
    );
  end

  byte_range_overlap u_in_ovl (
    .i_a_addr  (sb.storeAddress),
    .i_a_mode  (sb.storeMode),
    .i_b_addr  (sb.loadAddress),
    .i_b_mode  (sb.loadMode),
    .o_overlap (w_in_ovl)
  );

  // Head entry stays valid during its drain cycle, so it still stalls loads.
  assign sb.loadStall = !reset && sb.loadValid &&
                        ((|(w_entry_ovl & r_valid)) || (sb.storeValid && w_in_ovl));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      // Clear before set: when full, head == tail and the new store must win.
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= sb.storeAddress;
        r_data[r_tail]  <= sb.storeData;
        r_mode[r_tail]  <= sb.storeMode;
        r_tail          <= r_tail + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, X = 2'd3;

  typedef struct {
    logic rst, sv; logic [31:0] sa, sd; logic [1:0] sm;
    logic lv; logic [31:0] la; logic [1:0] lm; logic de;
    logic rdy, stl, mw; logic [31:0] ma, md; logic [1:0] mm; logic emp;
  } vec_t;

  typedef struct { logic [31:0] addr, data; logic [1:0] mode; } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  ent_t q[$];

  store_buffer_if sb();

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void add(logic rst, logic sv, logic [31:0] sa, logic [31:0] sd, logic [1:0] sm,
                              logic lv, logic [31:0] la, logic [1:0] lm, logic de,
                              logic rdy, logic stl, logic mw, logic [31:0] ma, logic [31:0] md,
                              logic [1:0] mm, logic emp);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sa = sa; v.sd = sd; v.sm = sm;
    v.lv = lv; v.la = la; v.lm = lm; v.de = de;
    v.rdy = rdy; v.stl = stl; v.mw = mw; v.ma = ma; v.md = md; v.mm = mm; v.emp = emp;
    tbl.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    reset           = v.rst;
    sb.storeValid   = v.sv;
    sb.storeAddress = v.sa;
    sb.storeData    = v.sd;
    sb.storeMode    = mem_mode_e'(v.sm);
    sb.loadValid    = v.lv;
    sb.loadAddress  = v.la;
    sb.loadMode     = mem_mode_e'(v.lm);
    sb.drainEn      = v.de;
  endtask

  task automatic compare(input string tag, input vec_t v);
    chk({tag, ".storeReady"},   32'(sb.storeReady),   32'(v.rdy));
    chk({tag, ".loadStall"},    32'(sb.loadStall),    32'(v.stl));
    chk({tag, ".memWrite"},     32'(sb.memWrite),     32'(v.mw));
    chk({tag, ".memAddress"},   sb.memAddress,        v.ma);
    chk({tag, ".memWriteData"}, sb.memWriteData,      v.md);
    chk({tag, ".memMode"},      32'(sb.memMode),      32'(v.mm));
    chk({tag, ".empty"},        32'(sb.empty),        32'(v.emp));
  endtask

  function automatic int msize(logic [1:0] m);
    return (m == B) ? 1 : (m == H) ? 2 : 4;
  endfunction

  function automatic bit ovl(logic [31:0] a, logic [1:0] am, logic [31:0] b, logic [1:0] bm);
    longint alo = longint'(a);
    longint blo = longint'(b);
    longint ahi = alo + msize(am) - 1;
    longint bhi = blo + msize(bm) - 1;
    return (alo <= bhi) && (blo <= ahi);
  endfunction

  initial begin
    vec_t v;
    sb.storeValid = 1'b0; sb.storeAddress = '0; sb.storeData = '0; sb.storeMode = MEM_BYTE;
    sb.loadValid = 1'b0; sb.loadAddress = '0; sb.loadMode = MEM_BYTE; sb.drainEn = 1'b0;

    //  rst sv  sa            sd            sm lv la            lm de | rdy stl mw ma            md            mm emp
    add(1, 0, 0,            0,            B, 0, 0,            B, 0,   1, 0, 0, 0,            0,            B, 1);
    add(0, 1, 32'h100,      32'hDEADBEEF, W, 0, 0,            B, 1,   1, 0, 0, 0,            0,            B, 1);
    add(0, 0, 0,            0,            B, 0, 0,            B, 1,   1, 0, 1, 32'h100,      32'hDEADBEEF, W, 0);
    add(0, 0, 0,            0,            B, 0, 0,            B, 1,   1, 0, 0, 0,            0,            B, 1);
    add(0, 1, 32'h1000,     1,            W, 0, 0,            B, 0,   1, 0, 0, 0,            0,            B, 1);
    add(0, 1, 32'h1004,     2,            W, 0, 0,            B, 0,   1, 0, 0, 32'h1000,     1,            W, 0);
    add(0, 1, 32'h1008,     3,            W, 0, 0,            B, 0,   1, 0, 0, 32'h1000,     1,            W, 0);
    add(0, 1, 32'h100C,     4,            W, 0, 0,            B, 0,   1, 0, 0, 32'h1000,     1,            W, 0);
    add(0, 1, 32'h1010,     5,            W, 0, 0,            B, 0,   0, 0, 0, 32'h1000,     1,            W, 0);
    add(0, 1, 32'h1010,     5,            W, 0, 0,            B, 1,   1, 0, 1, 32'h1000,     1,            W, 0);
    add(0, 0, 0,            0,            B, 0, 0,            B, 1,   1, 0, 1, 32'h1004,     2,            W, 0);
    add(0, 0, 0,            0,            B, 0, 0,            B, 1,   1, 0, 1, 32'h1008,     3,            W, 0);
    add(0, 0, 0,            0,            B, 0, 0,            B, 1,   1, 0, 1, 32'h100C,     4,            W, 0);
    add(0, 0, 0,            0,            B, 0, 0,            B, 1,   1, 0, 1, 32'h1010,     5,            W, 0);
    add(0, 0, 0,            0,            B, 0, 0,            B, 1,   1, 0, 0, 0,            0,            B, 1);
    add(0, 1, 32'h203,      32'hAAAA,     H, 1, 32'h200,      W, 0,   1, 1, 0, 0,            0,            B, 1);
    add(0, 0, 0,            0,            B, 1, 32'h200,      W, 0,   1, 1, 0, 32'h203,      32'hAAAA,     H, 0);
    add(0, 0, 0,            0,            B, 1, 32'h205,      B, 0,   1, 0, 0, 32'h203,      32'hAAAA,     H, 0);
    add(0, 0, 0,            0,            B, 1, 32'h200,      W, 1,   1, 1, 1, 32'h203,      32'hAAAA,     H, 0);
    add(0, 0, 0,            0,            B, 1, 32'h200,      W, 0,   1, 0, 0, 0,            0,            B, 1);
    add(0, 1, 32'h10,       32'h5A,       B, 1, 32'h10,       B, 0,   1, 1, 0, 0,            0,            B, 1);
    add(0, 0, 0,            0,            B, 1, 32'h10,       B, 1,   1, 1, 1, 32'h10,       32'h5A,       B, 0);
    add(0, 0, 0,            0,            B, 1, 32'h10,       B, 0,   1, 0, 0, 0,            0,            B, 1);
    add(0, 1, 32'hFFFFFFFE, 32'h77,       W, 1, 32'h0,        B, 0,   1, 0, 0, 0,            0,            B, 1);
    add(0, 0, 0,            0,            B, 1, 32'hFFFFFFFF, B, 0,   1, 1, 0, 32'hFFFFFFFE, 32'h77,       W, 0);
    add(0, 0, 0,            0,            B, 1, 32'h0,        B, 0,   1, 0, 0, 32'hFFFFFFFE, 32'h77,       W, 0);
    add(0, 1, 32'h300,      32'h11,       B, 0, 0,            B, 0,   1, 0, 0, 32'hFFFFFFFE, 32'h77,       W, 0);
    add(0, 1, 32'h301,      32'h22,       B, 0, 0,            B, 0,   1, 0, 0, 32'hFFFFFFFE, 32'h77,       W, 0);
    add(1, 0, 0,            0,            B, 1, 32'h300,      W, 1,   1, 0, 0, 0,            0,            B, 1);
    add(0, 0, 0,            0,            B, 0, 0,            B, 1,   1, 0, 0, 0,            0,            B, 1);
    add(0, 1, 32'h400,      32'h99,       X, 0, 0,            B, 0,   1, 0, 0, 0,            0,            B, 1);
    add(0, 0, 0,            0,            B, 1, 32'h403,      B, 0,   1, 1, 0, 32'h400,      32'h99,       X, 0);
    add(0, 0, 0,            0,            B, 1, 32'h404,      B, 1,   1, 0, 1, 32'h400,      32'h99,       X, 0);
    add(0, 0, 0,            0,            B, 0, 0,            B, 0,   1, 0, 0, 0,            0,            B, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      compare($sformatf("vec%0d", i), tbl[i]);
    end

    // Randomized phase against a queue model; the buffer is empty here.
    q.delete();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] sbase, lbase;
      bit deq, enq, hit;
      @(negedge clk);
      sbase = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFF8 : 32'h200;
      lbase = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFFFFF8) : 32'h200;
      v.rst = ($urandom_range(0, 59) == 0);
      v.sv  = ($urandom_range(0, 2) != 0);
      v.sa  = sbase + 32'($urandom_range(0, 7));
      v.sd  = $urandom;
      v.sm  = 2'($urandom_range(0, 3));
      v.lv  = ($urandom_range(0, 1) == 0);
      v.la  = lbase + 32'($urandom_range(0, 7));
      v.lm  = 2'($urandom_range(0, 3));
      v.de  = ($urandom_range(0, 2) == 0);

      if (v.rst) begin
        v.rdy = 1; v.stl = 0; v.mw = 0; v.ma = 0; v.md = 0; v.mm = B; v.emp = 1;
      end else begin
        deq   = v.de && (q.size() > 0);
        v.mw  = deq;
        v.rdy = (q.size() < 4) || deq;
        v.emp = (q.size() == 0);
        v.ma  = v.emp ? 32'h0 : q[0].addr;
        v.md  = v.emp ? 32'h0 : q[0].data;
        v.mm  = v.emp ? B : q[0].mode;
        hit = v.sv && ovl(v.sa, v.sm, v.la, v.lm);
        foreach (q[k]) if (ovl(q[k].addr, q[k].mode, v.la, v.lm)) hit = 1;
        v.stl = v.lv && hit;
      end

      drive(v);
      #2;
      compare($sformatf("rnd%0d", n), v);

      if (v.rst) q.delete();
      else begin
        deq = v.de && (q.size() > 0);
        enq = v.sv && ((q.size() < 4) || deq);
        if (deq) void'(q.pop_front());
        if (enq) q.push_back('{addr: v.sa, data: v.sd, mode: v.sm});
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
